// File: rtl/pic16fantastic_bridge_pkg.sv
// Shared types, widths and packed-parameter field helpers for the
// pic16fantastic peripheral bridge.
package pic16fantastic_bridge_pkg;

  localparam int unsigned ERR_CNT_W  = 8;
  localparam int unsigned WAIT_W     = 4;
  localparam int unsigned TO_CNT_W   = 8;
  localparam int unsigned PACK_MAX_W = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Extract field idx of width fw from a packed per-channel parameter vector.
  function automatic logic [31:0] pack_field(input logic [PACK_MAX_W-1:0] vec,
                                             input int unsigned idx,
                                             input int unsigned fw);
    logic [PACK_MAX_W-1:0] sh;
    logic [31:0]           fmask;
    sh    = vec >> (idx * fw);
    fmask = (fw >= 32) ? '1 : ((32'd1 << fw) - 32'd1);
    return sh[31:0] & fmask;
  endfunction

  function automatic logic [WAIT_W-1:0] wait_field(input logic [PACK_MAX_W-1:0] vec,
                                                   input int unsigned idx);
    return WAIT_W'(pack_field(vec, idx, WAIT_W));
  endfunction

endpackage

// File: rtl/periph_addr_decoder.sv
// Mask-compare address decoder with lowest-index priority; one-hot select
// plus hit flag, purely combinational.
module periph_addr_decoder
  import pic16fantastic_bridge_pkg::*;
#(
  parameter int unsigned              NUM_CH  = 9,
  parameter int unsigned              ADDR_W  = 9,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE = '0,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_MASK = '1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [NUM_CH-1:0] sel_c,
  output logic              hit_c
);

  logic [NUM_CH-1:0] match;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_match
    localparam logic [ADDR_W-1:0] BASE =
      ADDR_W'(pack_field(PACK_MAX_W'(CH_BASE), 32'(i), ADDR_W));
    localparam logic [ADDR_W-1:0] MASK =
      ADDR_W'(pack_field(PACK_MAX_W'(CH_MASK), 32'(i), ADDR_W));
    assign match[i] = ((addr & MASK) == (BASE & MASK));
  end

  // First match wins so overlapping windows resolve deterministically.
  always_comb begin
    sel_c = '0;
    hit_c = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (match[i] && !hit_c) begin
        sel_c[i] = 1'b1;
        hit_c    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pic16fantastic_periph_bridge.sv
// Core-to-peripheral bridge: zero-wait channels complete combinationally,
// slow channels go through WAIT/DONE with wait states, ready and timeout.
module pic16fantastic_periph_bridge
  import pic16fantastic_bridge_pkg::*;
#(
  parameter int unsigned              NUM_CH  = 9,
  parameter int unsigned              ADDR_W  = 9,
  parameter int unsigned              DATA_W  = 8,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE = '0,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_MASK = '1,
  parameter logic [NUM_CH*WAIT_W-1:0] CH_WAIT = '0,
  parameter int unsigned              TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        bus_addr,
  input  logic                     bus_rd_en,
  input  logic                     bus_wr_en,
  input  logic [DATA_W-1:0]        bus_wdata,
  output logic [DATA_W-1:0]        bus_rdata,
  output logic                     bus_stall,
  output logic                     bus_err,
  output logic [NUM_CH-1:0]        ch_sel,
  output logic [NUM_CH-1:0]        ch_rd_en,
  output logic [NUM_CH-1:0]        ch_wr_en,
  output logic [DATA_W-1:0]        ch_wdata,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
  input  logic [NUM_CH-1:0]        ch_ready,
  output logic [ADDR_W-1:0]        err_addr,
  output logic [ERR_CNT_W-1:0]     err_count
);

  localparam int unsigned CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [CH_IDX_W-1:0]   ch_q, ch_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [TO_CNT_W-1:0]   to_cnt_q, to_cnt_d;
  logic                  err_pend_q, err_pend_d;
  logic [ADDR_W-1:0]     err_addr_q, err_addr_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;

  logic [NUM_CH-1:0]     hit_sel_c;
  logic                  hit_c;
  logic [CH_IDX_W-1:0]   hit_idx_c;
  logic [WAIT_W-1:0]     hit_wait_c;
  logic [CH_IDX_W-1:0]   cur_idx_c;
  logic [NUM_CH-1:0]     cur_sel_c;
  logic                  cur_ready_c;
  logic [DATA_W-1:0]     cur_rdata_c;
  logic                  req_c;

  periph_addr_decoder #(
    .NUM_CH  (NUM_CH),
    .ADDR_W  (ADDR_W),
    .CH_BASE (CH_BASE),
    .CH_MASK (CH_MASK)
  ) u_dec (
    .addr  (bus_addr),
    .sel_c (hit_sel_c),
    .hit_c (hit_c)
  );

  // Decoded channel index and its configured wait-state count.
  always_comb begin
    hit_idx_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (hit_sel_c[i]) hit_idx_c = CH_IDX_W'(i);
    end
    hit_wait_c = wait_field(PACK_MAX_W'(CH_WAIT), 32'(hit_idx_c));
  end

  // Active channel: live decode while idle, captured channel otherwise.
  assign cur_idx_c = (state_q == ST_IDLE) ? hit_idx_c : ch_q;

  always_comb begin
    cur_sel_c   = '0;
    cur_ready_c = 1'b0;
    cur_rdata_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (CH_IDX_W'(i) == cur_idx_c) begin
        cur_sel_c[i] = 1'b1;
        cur_ready_c  = ch_ready[i];
        cur_rdata_c  = ch_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_c = bus_rd_en | bus_wr_en;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ch_d        = ch_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    wait_cnt_d  = wait_cnt_q;
    to_cnt_d    = to_cnt_q;
    err_pend_d  = err_pend_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    bus_rdata   = '0;
    bus_stall   = 1'b0;
    bus_err     = 1'b0;
    ch_sel      = '0;
    ch_rd_en    = '0;
    ch_wr_en    = '0;
    ch_wdata    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_c && hit_c) begin
          if ((hit_wait_c == '0) && cur_ready_c) begin
            ch_sel    = cur_sel_c;
            ch_rd_en  = bus_rd_en ? cur_sel_c : '0;
            ch_wr_en  = bus_wr_en ? cur_sel_c : '0;
            ch_wdata  = bus_wdata;
            bus_rdata = cur_rdata_c;
          end else begin
            bus_stall  = 1'b1;
            addr_d     = bus_addr;
            ch_d       = hit_idx_c;
            rd_d       = bus_rd_en;
            wr_d       = bus_wr_en;
            wdata_d    = bus_wdata;
            wait_cnt_d = hit_wait_c;
            to_cnt_d   = '0;
            err_pend_d = 1'b0;
            state_d    = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        bus_stall = 1'b1;
        ch_sel    = cur_sel_c;
        ch_wdata  = wdata_q;
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end else if (cur_ready_c) begin
          rdata_d = cur_rdata_c;
          state_d = ST_DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_CNT_W'(1);
          if (to_cnt_d == TO_CNT_W'(TIMEOUT)) begin
            rdata_d    = '0;
            err_pend_d = 1'b1;
            err_addr_d = addr_q;
            if (err_count_q != '1) err_count_d = err_count_q + ERR_CNT_W'(1);
            state_d    = ST_DONE;
          end
        end
      end

      // Held core request is absorbed here; strobes fire even on timeout.
      ST_DONE: begin
        bus_rdata  = rdata_q;
        ch_sel     = cur_sel_c;
        ch_rd_en   = rd_q ? cur_sel_c : '0;
        ch_wr_en   = wr_q ? cur_sel_c : '0;
        ch_wdata   = wdata_q;
        bus_err    = err_pend_q;
        err_pend_d = 1'b0;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      ch_q        <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wait_cnt_q  <= '0;
      to_cnt_q    <= '0;
      err_pend_q  <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ch_q        <= ch_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      wait_cnt_q  <= wait_cnt_d;
      to_cnt_q    <= to_cnt_d;
      err_pend_q  <= err_pend_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_pic16fantastic_periph_bridge.sv
// Randomized scoreboard bench for pic16fantastic_periph_bridge.
`timescale 1ns/1ps
module tb_pic16fantastic_periph_bridge;

  localparam int NCH = 9;
  localparam int AW  = 9;
  localparam int DW  = 8;
  localparam int TO  = 15;

  localparam logic [NCH*AW-1:0] P_BASE = {9'h040, 9'h0C0, 9'h0A0, 9'h186, 9'h019,
                                          9'h030, 9'h085, 9'h100, 9'h180};
  localparam logic [NCH*AW-1:0] P_MASK = {9'h1FC, 9'h1FF, 9'h1F8, 9'h1FF, 9'h1FF,
                                          9'h1FF, 9'h1FF, 9'h1FF, 9'h1F0};
  localparam logic [NCH*4-1:0]  P_WAIT = {4'd1, 4'd15, 4'd2, 4'd1, 4'd0,
                                          4'd3, 4'd0, 4'd0, 4'd0};

  // Reference channel map, listed from channel 0 upward.
  int m_base [NCH] = '{'h180, 'h100, 'h085, 'h030, 'h019, 'h186, 'h0A0, 'h0C0, 'h040};
  int m_mask [NCH] = '{'h1F0, 'h1FF, 'h1FF, 'h1FF, 'h1FF, 'h1FF, 'h1F8, 'h1FF, 'h1FC};
  int m_wait [NCH] = '{0, 0, 0, 3, 0, 1, 2, 15, 1};

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     bus_addr;
  logic              bus_rd_en;
  logic              bus_wr_en;
  logic [DW-1:0]     bus_wdata;
  logic [DW-1:0]     bus_rdata;
  logic              bus_stall;
  logic              bus_err;
  logic [NCH-1:0]    ch_sel;
  logic [NCH-1:0]    ch_rd_en;
  logic [NCH-1:0]    ch_wr_en;
  logic [DW-1:0]     ch_wdata;
  logic [NCH*DW-1:0] ch_rdata;
  logic [NCH-1:0]    ch_ready;
  logic [AW-1:0]     err_addr;
  logic [7:0]        err_count;

  typedef struct {
    int ch;
    bit rd;
    bit wr;
    int wdata;
    int rdata;
    bit err;
    int err_addr;
    int err_cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_err_cnt  = 0;
  int   m_err_addr = 0;

  pic16fantastic_periph_bridge #(
    .NUM_CH  (NCH),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .CH_BASE (P_BASE),
    .CH_MASK (P_MASK),
    .CH_WAIT (P_WAIT),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_addr  (bus_addr),
    .bus_rd_en (bus_rd_en),
    .bus_wr_en (bus_wr_en),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_stall (bus_stall),
    .bus_err   (bus_err),
    .ch_sel    (ch_sel),
    .ch_rd_en  (ch_rd_en),
    .ch_wr_en  (ch_wr_en),
    .ch_wdata  (ch_wdata),
    .ch_rdata  (ch_rdata),
    .ch_ready  (ch_ready),
    .err_addr  (err_addr),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int model_decode(input int a);
    for (int i = 0; i < NCH; i++) begin
      if ((a & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
    end
    return -1;
  endfunction

  // Completion monitor: every strobe cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && ((ch_rd_en | ch_wr_en) != '0)) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'(ch_rd_en | ch_wr_en), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("ch_sel",    32'(ch_sel),    32'd1 << mon_e.ch);
        check("ch_rd_en",  32'(ch_rd_en),  mon_e.rd ? (32'd1 << mon_e.ch) : 32'd0);
        check("ch_wr_en",  32'(ch_wr_en),  mon_e.wr ? (32'd1 << mon_e.ch) : 32'd0);
        check("ch_wdata",  32'(ch_wdata),  32'(mon_e.wdata));
        check("bus_rdata", 32'(bus_rdata), 32'(mon_e.rdata));
        check("bus_err",   32'(bus_err),   32'(mon_e.err));
        check("done_stall", 32'(bus_stall), 32'd0);
        check("err_count", 32'(err_count), 32'(mon_e.err_cnt));
        if (mon_e.err) check("err_addr", 32'(err_addr), 32'(mon_e.err_addr));
      end
    end else if (rst_n && bus_err) begin
      check("stray_bus_err", 32'(bus_err), 32'd0);
    end
  end

  task automatic do_access(input int addr, input bit rd, input bit wr, input bit rdy,
                           input int rv, input bit scramble);
    int   c;
    int   lat;
    int   exp_lat;
    exp_t e;
    c = model_decode(addr);
    bus_addr  = AW'(addr);
    bus_rd_en = rd;
    bus_wr_en = wr;
    bus_wdata = DW'($urandom);
    for (int i = 0; i < NCH; i++) begin
      ch_rdata[i*DW +: DW] = DW'($urandom);
      ch_ready[i]          = 1'($urandom_range(0, 1));
    end
    if (c < 0) begin
      @(negedge clk);
      check("unmapped_stall", 32'(bus_stall), 32'd0);
      check("unmapped_rdata", 32'(bus_rdata), 32'd0);
      check("unmapped_sel",   32'(ch_sel),    32'd0);
      @(posedge clk); #1;
      bus_rd_en = 1'b0;
      bus_wr_en = 1'b0;
      return;
    end
    ch_rdata[c*DW +: DW] = DW'(rv);
    ch_ready[c]          = rdy;
    if (!rdy) begin
      m_err_addr = addr;
      if (m_err_cnt < 255) m_err_cnt++;
    end
    e.ch       = c;
    e.rd       = rd;
    e.wr       = wr;
    e.wdata    = int'(bus_wdata);
    e.rdata    = rdy ? (rv & 'hFF) : 0;
    e.err      = !rdy;
    e.err_addr = m_err_addr;
    e.err_cnt  = m_err_cnt;
    sb.push_back(e);
    if (m_wait[c] == 0 && rdy) exp_lat = 0;
    else if (rdy)              exp_lat = m_wait[c] + 2;
    else                       exp_lat = m_wait[c] + TO + 1;
    lat = 0;
    @(negedge clk);
    while (bus_stall && lat < 200) begin
      lat++;
      @(posedge clk); #1;
      if (scramble) begin
        bus_addr  = AW'($urandom);
        bus_wdata = DW'($urandom);
        for (int i = 0; i < NCH; i++) begin
          if (i != c) ch_rdata[i*DW +: DW] = DW'($urandom);
        end
      end
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
    bus_rd_en = 1'b0;
    bus_wr_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"},  32'(bus_stall), 32'd0);
    check({tag, "_rdata"},  32'(bus_rdata), 32'd0);
    check({tag, "_err"},    32'(bus_err),   32'd0);
    check({tag, "_sel"},    32'(ch_sel),    32'd0);
    check({tag, "_strobe"}, 32'(ch_rd_en | ch_wr_en), 32'd0);
    check({tag, "_eaddr"},  32'(err_addr),  32'd0);
    check({tag, "_ecount"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    int k;
    int op;
    rst_n     = 1'b0;
    bus_addr  = '0;
    bus_rd_en = 1'b0;
    bus_wr_en = 1'b0;
    bus_wdata = '0;
    ch_rdata  = '0;
    ch_ready  = '1;
    #3;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("idle");

    // Fast path, slow write with address scrambling, timeout.
    do_access('h085, 1'b1, 1'b0, 1'b1, 'hA5, 1'b0);
    do_access('h030, 1'b0, 1'b1, 1'b1, 'h00, 1'b1);
    do_access('h019, 1'b1, 1'b0, 1'b0, 'h5A, 1'b1);
    check("err_count_one", 32'(err_count), 32'd1);
    check("err_addr_019",  32'(err_addr),  32'h019);

    // Overlapping windows resolve to channel 0; unmapped address.
    do_access('h186, 1'b1, 1'b0, 1'b1, 'h3C, 1'b0);
    do_access('h1FF, 1'b1, 1'b1, 1'b1, 'h11, 1'b0);

    // Reset pulsed in the middle of a slow write.
    bus_addr  = 9'h030;
    bus_rd_en = 1'b0;
    bus_wr_en = 1'b1;
    bus_wdata = 8'h77;
    ch_ready  = '1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_wait_stall", 32'(bus_stall), 32'd1);
    rst_n     = 1'b0;
    bus_wr_en = 1'b0;
    #1;
    check_reset_outputs("abort");
    m_err_cnt  = 0;
    m_err_addr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_abort_stall", 32'(bus_stall), 32'd0);

    // Simultaneous read and write on slow channels.
    do_access('h0A3, 1'b1, 1'b1, 1'b1, 'hC3, 1'b1);
    do_access('h030, 1'b1, 1'b1, 1'b1, 'h96, 1'b1);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        a = int'($urandom_range(0, 511));
      end else begin
        k = int'($urandom_range(0, NCH - 1));
        a = (m_base[k] & m_mask[k]) | (int'($urandom) & ~m_mask[k] & 'h1FF);
      end
      op = int'($urandom_range(1, 3));
      do_access(a, op[0], op[1], $urandom_range(0, 7) != 0, int'($urandom), 1'b1);
    end

    repeat (260) do_access('h019, 1'b1, 1'b0, 1'b0, int'($urandom), 1'b0);
    check("err_count_sat", 32'(err_count), 32'd255);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
